// File: rtl/mdu_pkg.sv
// Shared op codes, HI/LO select constants and op classification helpers for the
// multiply/divide unit and the decoder that drives it.
package mdu_pkg;

   localparam logic [2:0] MDU_MULTU = 3'b000;
   localparam logic [2:0] MDU_MULT  = 3'b001;
   localparam logic [2:0] MDU_DIVU  = 3'b010;
   localparam logic [2:0] MDU_DIV   = 3'b011;
   localparam logic [2:0] MDU_MOVE  = 3'b100;
   localparam logic [2:0] MDU_MADD  = 3'b101;
   localparam logic [2:0] MDU_MSUB  = 3'b110;
   localparam logic [2:0] MDU_RSVD  = 3'b111;

   localparam logic MDU_HI = 1'b0;
   localparam logic MDU_LO = 1'b1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mdu_state_e;

   function automatic logic is_long_op(input logic [2:0] op);
      return (op != MDU_MOVE) && (op != MDU_RSVD);
   endfunction

   function automatic logic is_div_op(input logic [2:0] op);
      return (op == MDU_DIVU) || (op == MDU_DIV);
   endfunction

endpackage

// File: rtl/mdu_compute.sv
// Combinational result generator: produces the next {HI,LO} for a latched
// multiply/divide command and flags division by zero.
module mdu_compute
   import mdu_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [63:0] hilo,
   output logic [63:0] hilo_next,
   output logic        div_zero
);

   logic signed [63:0] a_s;
   logic signed [63:0] b_s;
   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic        [31:0] b_safe;
   logic        [31:0] q_u;
   logic        [31:0] r_u;
   logic signed [31:0] sdiv_b;
   logic signed [31:0] q_s;
   logic signed [31:0] r_s;
   logic               s_ovf;

   assign a_s    = {{32{a[31]}}, a};
   assign b_s    = {{32{b[31]}}, b};
   assign prod_s = a_s * b_s;
   assign prod_u = {32'd0, a} * {32'd0, b};

   assign div_zero = is_div_op(op) && (b == 32'd0);
   assign b_safe   = (b == 32'd0) ? 32'd1 : b;

   assign q_u = a / b_safe;
   assign r_u = a % b_safe;

   // Dividing the most negative value by 1 instead of -1 yields exactly the
   // required saturated result (quotient 0x80000000, remainder 0).
   assign s_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
   assign sdiv_b = s_ovf ? 32'sd1 : $signed(b_safe);
   assign q_s    = $signed(a) / sdiv_b;
   assign r_s    = $signed(a) % sdiv_b;

   always_comb begin
      hilo_next = hilo;
      case (op)
         MDU_MULTU: hilo_next = prod_u;
         MDU_MULT:  hilo_next = prod_s;
         MDU_MADD:  hilo_next = hilo + prod_s;
         MDU_MSUB:  hilo_next = hilo - prod_s;
         MDU_DIVU:  hilo_next = {r_u, q_u};
         MDU_DIV:   hilo_next = {r_s, q_s};
         default:   hilo_next = hilo;
      endcase
   end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit: owns HI/LO, runs a fixed-latency busy period
// per command and commits the result on the final busy edge.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [2:0]  Op,
   input  logic        Write,
   input  logic        Addr,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] Out
);

   localparam int CNT_W = 16;

   mdu_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        op_q, op_d;
   logic [31:0]       a_q, a_d;
   logic [31:0]       b_q, b_d;
   logic [63:0]       hilo_lat_q, hilo_lat_d;
   logic [31:0]       hi_q, hi_d;
   logic [31:0]       lo_q, lo_d;

   logic [63:0]       hilo_next;
   logic              div_zero;

   mdu_compute u_compute (
      .op        (op_q),
      .a         (a_q),
      .b         (b_q),
      .hilo      (hilo_lat_q),
      .hilo_next (hilo_next),
      .div_zero  (div_zero)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      hilo_lat_d = hilo_lat_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      case (state_q)
         ST_IDLE: begin
            if (Start && is_long_op(Op)) begin
               state_d    = ST_BUSY;
               op_d       = Op;
               a_d        = A;
               b_d        = B;
               hilo_lat_d = {hi_q, lo_q};
               cnt_d      = is_div_op(Op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
            end else if (Write && !Start) begin
               if (Addr == MDU_LO) lo_d = A;
               else                hi_d = A;
            end
         end
         ST_BUSY: begin
            // Start and Write are deliberately not looked at while busy.
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               if (!div_zero) {hi_d, lo_d} = hilo_next;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         hilo_lat_q <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         hilo_lat_q <= hilo_lat_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
      end
   end

   assign Busy = (state_q == ST_BUSY);
   assign HI   = hi_q;
   assign LO   = lo_q;
   assign Out  = Addr ? lo_q : hi_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed cases plus randomized commands
// checked against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;
   import mdu_pkg::*;

   localparam int MUL_N = 5;
   localparam int DIV_N = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        Start = 1'b0;
   logic [2:0]  Op = 3'd0;
   logic        Write = 1'b0;
   logic        Addr = 1'b0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        Busy;
   logic [31:0] HI, LO, Out;

   mult_div_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .reset(reset), .Start(Start), .Op(Op), .Write(Write),
      .Addr(Addr), .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO), .Out(Out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
      logic [2:0]  op;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] hi_m = '0;
   logic [31:0] lo_m = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference semantics straight from the architectural definition.
   function automatic int ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, q, r;
      logic [63:0] acc, p;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      acc = {hi_m, lo_m};
      case (op)
         MDU_MULTU: begin p = 64'(a) * 64'(b); {hi_m, lo_m} = p; return MUL_N; end
         MDU_MULT:  begin {hi_m, lo_m} = 64'(sa * sb); return MUL_N; end
         MDU_MADD:  begin {hi_m, lo_m} = acc + 64'(sa * sb); return MUL_N; end
         MDU_MSUB:  begin {hi_m, lo_m} = acc - 64'(sa * sb); return MUL_N; end
         MDU_DIVU: begin
            if (b != 0) begin lo_m = a / b; hi_m = a % b; end
            return DIV_N;
         end
         MDU_DIV: begin
            if (b != 0) begin
               q = sa / sb; r = sa % sb;
               lo_m = q[31:0]; hi_m = r[31:0];
            end
            return DIV_N;
         end
         default: return 0;
      endcase
   endfunction

   // Monitor: every falling Busy is a commit that must match the queue head.
   int   busy_cnt = 0;
   logic prev_busy = 1'b0;
   always @(negedge clk) begin
      if (!reset) begin
         busy_cnt  = 0;
         prev_busy = 1'b0;
      end else begin
         if (Busy) busy_cnt++;
         else if (prev_busy) begin
            if (sb_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_commit: HI=0x%08h LO=0x%08h with no pending op", HI, LO);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk($sformatf("busy_len_op%0d", e.op), 32'(busy_cnt), 32'(e.cyc));
               chk($sformatf("commit_hi_op%0d", e.op), HI, e.hi);
               chk($sformatf("commit_lo_op%0d", e.op), LO, e.lo);
            end
            busy_cnt = 0;
         end
         prev_busy = Busy;
      end
   end

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (Busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (Busy) begin
         n_checks++; n_fail++;
         $display("FAIL idle_timeout: Busy still 1 after %0d cycles", n);
      end
   endtask

   task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic with_write);
      exp_t e;
      @(negedge clk);
      Start = 1'b1; Op = op; A = a; B = b;
      Write = with_write; Addr = MDU_HI;
      if (is_long_op(op)) begin
         e.cyc = ref_op(op, a, b);
         e.hi  = hi_m; e.lo = lo_m; e.op = op;
         sb_q.push_back(e);
      end
      @(negedge clk);
      Start = 1'b0; Write = 1'b0;
   endtask

   task automatic write_reg(input logic sel, input logic [31:0] v);
      @(negedge clk);
      Write = 1'b1; Addr = sel; A = v;
      @(negedge clk);
      Write = 1'b0;
      if (sel == MDU_LO) lo_m = v; else hi_m = v;
      #1 chk(sel ? "mtlo_out" : "mthi_out", Out, v);
   endtask

   task automatic check_out(input string name, input logic [31:0] eh, input logic [31:0] el);
      Addr = MDU_HI;
      #1 chk({name, "_hi"}, Out, eh);
      chk({name, "_hiport"}, HI, eh);
      Addr = MDU_LO;
      #1 chk({name, "_lo"}, Out, el);
      chk({name, "_loport"}, LO, el);
   endtask

   initial begin
      logic [31:0] old_hi, old_lo;
      // Reset
      repeat (3) @(negedge clk);
      #1 chk("rst_busy", {31'd0, Busy}, 32'd0);
      chk("rst_out", Out, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check_out("rst", 32'd0, 32'd0);
      chk("rst_busy_rel", {31'd0, Busy}, 32'd0);

      // Directed arithmetic with literal expectations
      start_op(MDU_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);
      wait_idle();
      check_out("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      start_op(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
      wait_idle();
      check_out("multu", 32'h0000_0001, 32'hFFFF_FFFE);
      start_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
      wait_idle();
      check_out("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      start_op(MDU_DIVU, 32'd7, 32'd0, 1'b0);
      wait_idle();
      check_out("divu_zero", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      write_reg(MDU_HI, 32'd0);
      write_reg(MDU_LO, 32'd5);
      start_op(MDU_MADD, 32'd3, 32'd4, 1'b0);
      wait_idle();
      check_out("madd", 32'd0, 32'h11);
      write_reg(MDU_LO, 32'd0);
      start_op(MDU_MSUB, 32'd1, 32'd1, 1'b0);
      wait_idle();
      check_out("msub", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      start_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      wait_idle();
      check_out("div_ovf", 32'd0, 32'h8000_0000);

      // Write and Start both pulsed while busy must be ignored
      old_hi = hi_m; old_lo = lo_m;
      start_op(MDU_MULTU, 32'd6, 32'd7, 1'b0);
      @(negedge clk);
      Write = 1'b1; Addr = MDU_HI; A = 32'hDEAD_BEEF;
      Start = 1'b1; Op = MDU_DIVU; B = 32'd3;
      @(negedge clk);
      Write = 1'b0; Start = 1'b0;
      #1 chk("busy_out_hi", Out, old_hi);
      wait_idle();
      check_out("busy_write", 32'd0, 32'd42);

      // Start wins over a simultaneous Write
      start_op(MDU_MULT, 32'd10, 32'hFFFF_FFFD, 1'b1);
      wait_idle();
      check_out("start_vs_write", 32'hFFFF_FFFF, 32'hFFFF_FFE2);

      // Reserved and move op codes with Start never go busy
      start_op(MDU_RSVD, 32'd9, 32'd9, 1'b0);
      #1 chk("rsvd_busy", {31'd0, Busy}, 32'd0);
      start_op(MDU_MOVE, 32'd9, 32'd9, 1'b0);
      #1 chk("move_busy", {31'd0, Busy}, 32'd0);
      check_out("rsvd", hi_m, lo_m);

      // Reset dropped on the third busy cycle of a divide
      start_op(MDU_DIV, 32'd100, 32'd7, 1'b0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      sb_q.delete();
      hi_m = '0; lo_m = '0;
      #1 chk("midrst_busy", {31'd0, Busy}, 32'd0);
      chk("midrst_hi", HI, 32'd0);
      chk("midrst_lo", LO, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (DIV_N + 3) @(negedge clk);
      chk("midrst_nocommit_busy", {31'd0, Busy}, 32'd0);
      check_out("midrst_after", 32'd0, 32'd0);

      // Randomized commands against the model
      for (int i = 0; i < 60; i++) begin
         int unsigned r;
         logic [2:0]  op;
         logic [31:0] a, b;
         r = $urandom_range(0, 11);
         a = $urandom;
         b = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
         if (r < 2) begin
            write_reg(r[0], a);
         end else begin
            case (r)
               2, 3: op = MDU_MULT;
               4:    op = MDU_MULTU;
               5, 6: op = MDU_DIV;
               7:    op = MDU_DIVU;
               8:    op = MDU_MADD;
               9:    op = MDU_MSUB;
               10:   begin op = MDU_DIV; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
               default: op = MDU_RSVD;
            endcase
            if ($urandom_range(0, 3) == 0) a = {28'd0, a[3:0]};
            start_op(op, a, b, 1'($urandom_range(0, 1)));
            wait_idle();
         end
         check_out("rand", hi_m, lo_m);
      end

      wait_idle();
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

- Multi-cycle multiply/divide unit that sits in the EX stage and executes the commands the instruction decoder issues on its MDM control lines: start, op, write, HI/LO select.
- Owns the architectural HI and LO registers.
- Signals busy so the hazard unit can stall later HI/LO-dependent instructions.
- Provides the HI/LO read value for MFHI/MFLO.

## Interface
Parameters:
- `MUL_CYCLES`, default 5, busy cycles for MULT/MULTU/MADD/MSUB.
- `DIV_CYCLES`, default 10, busy cycles for DIV/DIVU.

Ports:
- `clk` in 1: single clock, rising-edge.
- `reset` in 1: asynchronous, active-low.
- `Start` in 1: launch a multi-cycle op this cycle.
- `Op` in 3: op code, encodings listed under Operation.
- `Write` in 1: MTHI/MTLO strobe.
- `Addr` in 1: select, 0 = HI, 1 = LO. Used by `Write` and `Out`.
- `A` in 32: rs operand.
- `B` in 32: rt operand.
- `Busy` out 1: operation in progress.
- `HI` out 32: HI register.
- `LO` out 32: LO register.
- `Out` out 32: combinational read, `Addr ? LO : HI`.

## Operation
- `Op` encoding:
  - 000 MULTU, 001 MULT, 010 DIVU, 011 DIV.
  - 100 move (MF/MT, no start).
  - 101 MADD, 110 MSUB.
  - 111 reserved. `Start` with 111 is ignored: no busy, no change.
- States:
  - IDLE → BUSY when `Start` is sampled with a valid multi-cycle op.
  - BUSY → IDLE when the down-counter reaches 1 at an edge. HI/LO are committed on that same edge.
- On the start edge, latch `A`, `B`, `Op` and the current {HI,LO}. Load the counter with `MUL_CYCLES` or `DIV_CYCLES`.
- Results:
  - MULT: signed 32×32 → 64-bit product; {HI,LO} = product.
  - MULTU: same, unsigned.
  - MADD: {HI,LO} = latched {HI,LO} + signed product, 64-bit wrap.
  - MSUB: {HI,LO} = latched {HI,LO} − signed product, 64-bit wrap.
  - DIV: signed. LO = quotient truncated toward zero; HI = remainder, carrying the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Signed overflow 0x80000000 / −1: LO = 0x80000000, HI = 0.
- Divide by zero (`B` = 0): full `DIV_CYCLES` busy period, HI/LO left unchanged.
- `Write`: when IDLE and `Start` = 0, the selected register takes `A` on the edge.
- Boundary rules:
  - `Start` while BUSY: ignored.
  - `Write` while BUSY: ignored.
  - `Write` in the same cycle as `Start`: `Start` wins and `Write` is dropped.
- `reset` low at any time, including mid-operation, immediately forces:
  - state IDLE, counter 0;
  - HI = LO = 0;
  - latched operands cleared.

## Timing
- Reset values: `Busy` = 0, `HI` = 0, `LO` = 0, `Out` = 0.
- `Start` sampled at edge E0 → `Busy` is high for exactly N cycles, from after E0 through edge EN.
- At EN, HI/LO update and `Busy` falls together. New values are visible on `HI`/`LO`/`Out` in the cycle after EN.
- A new `Start` is accepted at EN+1 at the earliest.
- `Busy` is registered and never combinationally depends on `Start`. The decoder's stall logic ORs `Start` itself.
- `Out` is purely combinational from the HI/LO registers and `Addr`. During BUSY it reflects the pre-operation values.
- A `Write` at edge E updates the register, and `Out` shows it from E onward.

## Structure
- Shared package `mdu_pkg`:
  - op codes as localparams: `MDU_MULTU`, `MDU_MULT`, `MDU_DIVU`, `MDU_DIV`, `MDU_MOVE`, `MDU_MADD`, `MDU_MSUB`;
  - HI/LO select constants `MDU_HI` = 0, `MDU_LO` = 1.
- The decoder imports the same package.
- One sub-module, `mdu_compute`:
  - purely combinational;
  - inputs: latched op, A, B, {HI,LO};
  - outputs: next {HI,LO} and a divide-by-zero flag.
- The top level holds the FSM, counter, operand latches and HI/LO registers.

## Test plan
- Reset: assert `reset` = 0, then release → `Busy` = 0, HI = LO = 0.
- MULT, A = 0xFFFFFFFF, B = 2 → `Busy` high for 5 cycles, then HI = 0xFFFFFFFF, LO = 0xFFFFFFFE.
- MULTU with the same operands → HI = 0x00000001, LO = 0xFFFFFFFE.
- DIV, A = 0xFFFFFFF9 (−7), B = 2 → `Busy` high for 10 cycles, then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU, A = 7, B = 0 → `Busy` high for 10 cycles, HI/LO unchanged.
- MTLO A = 5, then MADD A = 3, B = 4 → LO = 0x11, HI = 0.
- MSUB from 0:0 with A = 1, B = 1 → HI = LO = 0xFFFFFFFF.
- MTHI pulsed during BUSY → ignored.
- `Write` and `Start` in the same cycle → only the start takes effect.
- `reset` dropped at busy cycle 3 of DIV → immediate `Busy` = 0, HI = LO = 0, and no later commit.
